// File: rtl/apb3_requester_pkg.sv
// Shared types and helpers for the APB3 requester.
package apb3_requester_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb3_req_state_e;

  // Counter width able to hold the value TimeoutCycles itself.
  function automatic int timeout_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb3_req_timeout.sv
// ACCESS-phase wait counter; expired fires in the ACCESS cycle whose
// stall brings the count up to TimeoutCycles.
module apb3_req_timeout
  import apb3_requester_pkg::*;
#(
  parameter int TimeoutCycles = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CntW = timeout_cnt_w(TimeoutCycles);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (clear)    cnt <= '0;
    else if (count_en) cnt <= cnt + CntW'(1);
  end

  assign expired = count_en && (cnt == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/apb3_requester.sv
// APB3 initiator: one request in, one SETUP/ACCESS transfer, one response out.
// Optional ACCESS timeout enabled by APB3_REQUESTER_TIMEOUT_EN.
module apb3_requester
  import apb3_requester_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 rsp_timeout_o,
  output logic [AddrWidth-1:0] PADDR,
  output logic [DataWidth-1:0] PWDATA,
  output logic                 PWRITE,
  output logic                 PSEL,
  output logic                 PENABLE,
  input  logic [DataWidth-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  apb3_req_state_e state, state_nxt;
  logic            tmo_expired;
  logic            xfer_done;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (xfer_done) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is gated by reset so every output reads 0 while RSTN is low.
  assign req_ready_o = (state == IDLE) && RSTN;
  assign PSEL        = (state == SETUP) || (state == ACCESS);
  assign PENABLE     = (state == ACCESS);
  assign rsp_valid_o = (state == RESP);
  assign xfer_done   = (state == ACCESS) && (PREADY || tmo_expired);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid_i) begin
        PADDR  <= req_addr_i;
        PWDATA <= req_wdata_i;
        PWRITE <= req_write_i;
      end
      // A real PREADY wins over a same-cycle expiry.
      if (xfer_done) begin
        rsp_err_o   <= PREADY ? PSLVERR : 1'b1;
        rsp_rdata_o <= (PREADY && !PWRITE) ? PRDATA : '0;
      end
    end
  end

`ifdef APB3_REQUESTER_TIMEOUT_EN
  apb3_req_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk     (CLK),
    .rst_n   (RSTN),
    .clear   (state == SETUP),
    .count_en((state == ACCESS) && !PREADY),
    .expired (tmo_expired)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)          rsp_timeout_o <= 1'b0;
    else if (xfer_done) rsp_timeout_o <= !PREADY;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign tmo_expired        = 1'b0;
  assign rsp_timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_apb3_requester.sv
// Directed bench for apb3_requester; follows APB3_REQUESTER_TIMEOUT_EN too.
module tb_apb3_requester;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        req_valid_i = 1'b0, req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        req_ready_o, rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic [31:0] PADDR, PWDATA, PRDATA = '0;
  logic        PWRITE, PSEL, PENABLE, PREADY = 1'b0, PSLVERR = 1'b0;

  int tests = 0;
  int fails = 0;

  apb3_requester #(.AddrWidth(32), .DataWidth(32), .TimeoutCycles(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive a request for the accept edge, then drop it.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wdata;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({PSEL, PENABLE, rsp_valid_o, req_ready_o, rsp_err_o, rsp_timeout_o, PWRITE} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000000",
        {PSEL, PENABLE, rsp_valid_o, req_ready_o, rsp_err_o, rsp_timeout_o, PWRITE});
    end
    tests++;
    if ({PADDR, PWDATA, rsp_rdata_o} !== 96'b0) begin
      fails++; $display("FAIL reset_data: got %h %h %h want 0", PADDR, PWDATA, rsp_rdata_o);
    end
    tick();
    RSTN = 1'b1;
    tick();
    tests++;
    if (req_ready_o !== 1'b1) begin
      fails++; $display("FAIL reset_idle_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_zero_wait_write();
    PREADY = 1'b1;
    issue(1'b1, 32'h0000_0004, 32'h0000_00A5);
    tests++;  // cycle 1: SETUP
    if ({PSEL, PENABLE, req_ready_o, PWRITE} !== 4'b1001 || PADDR !== 32'h4 || PWDATA !== 32'hA5) begin
      fails++; $display("FAIL wr_setup: got ctl=%b addr=%h data=%h want 1001 4 a5",
        {PSEL, PENABLE, req_ready_o, PWRITE}, PADDR, PWDATA);
    end
    tick();
    tests++;  // cycle 2: ACCESS
    if ({PSEL, PENABLE, rsp_valid_o} !== 3'b110) begin
      fails++; $display("FAIL wr_access: got %b want 110", {PSEL, PENABLE, rsp_valid_o});
    end
    tick();
    tests++;  // cycle 3: RESP
    if ({PSEL, PENABLE, rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 5'b00100 || rsp_rdata_o !== 32'h0) begin
      fails++; $display("FAIL wr_resp: got %b rdata=%h want 00100 0",
        {PSEL, PENABLE, rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o);
    end
    handshake();
    tests++;
    if ({rsp_valid_o, req_ready_o} !== 2'b01 || PADDR !== 32'h4 || PWRITE !== 1'b1) begin
      fails++; $display("FAIL wr_after: got %b addr=%h pwrite=%b want 01 4 1",
        {rsp_valid_o, req_ready_o}, PADDR, PWRITE);
    end
  endtask

  task automatic test_wait_read();
    int bad = 0;
    PREADY = 1'b0; PRDATA = 32'h1111_1111;
    issue(1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    tick();  // now cycle 2, first ACCESS
    for (int i = 0; i < 3; i++) begin
      if ({PSEL, PENABLE, PWRITE} !== 3'b110 || PADDR !== 32'h10 || rsp_valid_o !== 1'b0) bad++;
      tick();
    end
    PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;  // cycle 5
    if ({PSEL, PENABLE, PWRITE} !== 3'b110 || PADDR !== 32'h10) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL rd_wait_hold: got %0d bad ACCESS cycles want 0", bad);
    end
    tick();
    PRDATA = 32'h0;
    tests++;  // cycle 6
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEAD_BEEF || rsp_err_o !== 1'b0) begin
      fails++; $display("FAIL rd_wait_resp: got v=%b rdata=%h err=%b want 1 deadbeef 0",
        rsp_valid_o, rsp_rdata_o, rsp_err_o);
    end
    handshake();
  endtask

  task automatic test_slverr();
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_1234;
    issue(1'b0, 32'h0000_0008, 32'h0);
    tick(); tick();
    PSLVERR = 1'b0; PRDATA = 32'h0;
    tests++;
    if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b110 || rsp_rdata_o !== 32'h1234) begin
      fails++; $display("FAIL slverr: got %b rdata=%h want 110 1234",
        {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o);
    end
    handshake();
    tests++;
    if (rsp_valid_o !== 1'b0) begin
      fails++; $display("FAIL slverr_release: got %b want 0", rsp_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    PREADY = 1'b1; PRDATA = 32'h0000_5A5A;
    issue(1'b0, 32'h0000_000C, 32'h0);
    tick(); tick();  // RESP with 5a5a
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h20; req_wdata_i = 32'h77;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid_o, req_ready_o, PSEL} !== 3'b100 || rsp_rdata_o !== 32'h5A5A) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    tests++;
    if ({rsp_valid_o, req_ready_o, PSEL} !== 3'b010) begin
      fails++; $display("FAIL bp_idle: got %b want 010", {rsp_valid_o, req_ready_o, PSEL});
    end
    tick();
    req_valid_i = 1'b0;
    tests++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h20 || PWDATA !== 32'h77) begin
      fails++; $display("FAIL bp_accept: got %b addr=%h data=%h want 101 20 77",
        {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    tick(); tick();
    handshake();
  endtask

  task automatic test_timeout();
    int bad = 0;
    PREADY = 1'b0; PRDATA = 32'hABCD_0000;
    issue(1'b0, 32'h0000_0030, 32'h0);
    tick();  // first ACCESS cycle
`ifdef APB3_REQUESTER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      if ({PSEL, PENABLE, rsp_valid_o} !== 3'b110) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL tmo_access: got %0d bad cycles want 0", bad);
    end
    tests++;
    if ({PSEL, PENABLE, rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 5'b00111 || rsp_rdata_o !== 32'h0) begin
      fails++; $display("FAIL tmo_resp: got %b rdata=%h want 00111 0",
        {PSEL, PENABLE, rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o);
    end
    handshake();
    // PREADY arriving in the 8th ACCESS cycle is a normal completion.
    PRDATA = 32'h0000_0088;
    issue(1'b0, 32'h0000_0034, 32'h0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    tests++;
    if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'h88) begin
      fails++; $display("FAIL tmo_edge: got %b rdata=%h want 100 88",
        {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o);
    end
    handshake();
`else
    for (int i = 0; i < 100; i++) begin
      if ({PSEL, PENABLE, rsp_valid_o} !== 3'b110) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL notmo_wait: got %0d bad cycles want 0", bad);
    end
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    tests++;
    if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'hABCD_0000) begin
      fails++; $display("FAIL notmo_resp: got %b rdata=%h want 100 abcd0000",
        {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o);
    end
    handshake();
`endif
  endtask

  task automatic test_reset_mid_access();
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0040, 32'h0);
    tick(); tick();  // second ACCESS (wait) cycle
    #2 RSTN = 1'b0;
    #1;
    tests++;
    if ({PSEL, PENABLE, rsp_valid_o, req_ready_o} !== 4'b0000 || PADDR !== 32'h0) begin
      fails++; $display("FAIL rst_mid: got %b addr=%h want 0000 0",
        {PSEL, PENABLE, rsp_valid_o, req_ready_o}, PADDR);
    end
    tick();
    RSTN = 1'b1;
    tick();
    tests++;
    if ({req_ready_o, rsp_valid_o, PSEL} !== 3'b100) begin
      fails++; $display("FAIL rst_idle: got %b want 100", {req_ready_o, rsp_valid_o, PSEL});
    end
    PREADY = 1'b1; PRDATA = 32'hCAFE_0001;
    issue(1'b0, 32'h0000_0044, 32'h0);
    tick(); tick();
    tests++;
    if ({rsp_valid_o, rsp_err_o} !== 2'b10 || rsp_rdata_o !== 32'hCAFE_0001) begin
      fails++; $display("FAIL rst_fresh: got %b rdata=%h want 10 cafe0001",
        {rsp_valid_o, rsp_err_o}, rsp_rdata_o);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_backpressure();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
